// File: rtl/cga_isa_regs.sv
// ISA-side register front end for the CGA/MDA/Tandy video path: I/O decode, mode/color
// registers, CRTC strobes, status port, optional Tandy palette, memory wait states and blink.
module cga_isa_regs #(
   parameter logic [15:0] IO_BASE_ADDR     = 16'h3D0,
   parameter int          TANDY_EN         = 0,
   parameter int          USE_BUS_WAIT     = 1,
   parameter logic [4:0]  WAIT_SLOT_A      = 5'd17,
   parameter logic [4:0]  WAIT_SLOT_B      = 5'd20,
   parameter logic [7:0]  WAIT_TIMEOUT     = 8'd64,
   parameter int          BLINK_FROM_VSYNC = 0,
   parameter logic [23:0] BLINK_MAX        = 24'd0,
   parameter logic [4:0]  BLINK_FRAMES     = 5'd8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] bus_a,
   input  logic        bus_aen,
   input  logic        bus_ior_l,
   input  logic        bus_iow_l,
   input  logic        bus_memr_l,
   input  logic        bus_memw_l,
   input  logic        bus_mem_cs,
   input  logic [7:0]  bus_d,
   output logic [7:0]  bus_out,
   output logic        bus_dir,
   output logic        bus_rdy,
   input  logic [4:0]  clk_seq,
   input  logic        vsync_l,
   input  logic        display_enable,
   input  logic [7:0]  crtc_data,
   input  logic        splashscreen,
   output logic        crtc_cs,
   output logic        crtc_wr,
   output logic        crtc_rd,
   output logic [7:0]  control_reg,
   output logic [7:0]  color_reg,
   input  logic [3:0]  pal_idx,
   output logic [3:0]  pal_out,
   output logic        blink
);

   localparam logic [15:0] CTRL_ADDR   = IO_BASE_ADDR + 16'h0008;
   localparam logic [15:0] COLOR_ADDR  = IO_BASE_ADDR + 16'h0009;
   localparam logic [15:0] STATUS_ADDR = IO_BASE_ADDR + 16'h000A;
   localparam logic [15:0] TDATA_ADDR  = IO_BASE_ADDR + 16'h000E;
   localparam logic [12:0] CRTC_PAGE   = IO_BASE_ADDR[15:3];

   // ---------------------------------------------------------------- decode
   logic io_en;
   logic ctrl_cs;
   logic color_cs;
   logic status_cs;

   assign io_en     = ~bus_aen;
   assign crtc_cs   = io_en & (bus_a[15:3] == CRTC_PAGE);
   assign ctrl_cs   = io_en & (bus_a == CTRL_ADDR);
   assign color_cs  = io_en & (bus_a == COLOR_ADDR);
   assign status_cs = io_en & (bus_a == STATUS_ADDR);

   // ---------------------------------------------------------- synchronisers
   // strobe vector bit order: {ior, iow, memr, memw}
   logic [3:0] strb_raw;
   logic [3:0] strb_meta_reg;
   logic [3:0] strb_sync_reg;
   logic [1:0] io_prev_reg;
   logic       vs_meta_reg;
   logic       vs_sync_reg;
   logic       de_meta_reg;
   logic       de_sync_reg;

   assign strb_raw = {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         strb_meta_reg <= 4'hF;
         strb_sync_reg <= 4'hF;
         io_prev_reg   <= 2'b11;
         vs_meta_reg   <= 1'b1;
         vs_sync_reg   <= 1'b1;
         de_meta_reg   <= 1'b0;
         de_sync_reg   <= 1'b0;
      end else begin
         strb_meta_reg <= strb_raw;
         strb_sync_reg <= strb_meta_reg;
         io_prev_reg   <= strb_sync_reg[3:2];
         vs_meta_reg   <= vsync_l;
         vs_sync_reg   <= vs_meta_reg;
         de_meta_reg   <= display_enable;
         de_sync_reg   <= de_meta_reg;
      end
   end

   // Falling edges of the synced strobes fire once per access however long it is held.
   logic ior_fall;
   logic iow_fall;

   assign ior_fall = io_prev_reg[1] & ~strb_sync_reg[3];
   assign iow_fall = io_prev_reg[0] & ~strb_sync_reg[2];

   // ------------------------------------------------------ register file
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         control_reg <= 8'h28;
         color_reg   <= 8'h00;
         crtc_wr     <= 1'b0;
         crtc_rd     <= 1'b0;
      end else begin
         if (iow_fall && ctrl_cs) begin
            control_reg <= bus_d;
         end
         if (iow_fall && color_cs) begin
            color_reg <= bus_d;
         end
         crtc_wr <= iow_fall & crtc_cs;
         crtc_rd <= ior_fall & crtc_cs;
      end
   end

   // --------------------------------------------------- palette / Tandy
   generate
      if (TANDY_EN != 0) begin : g_tandy
         logic [4:0] idx_reg;
         logic [3:0] palette_reg [16];
         logic       tdata_cs;
         logic       pal_we;

         assign tdata_cs = io_en & (bus_a == TDATA_ADDR);
         // Only indices 10h-1Fh address the palette; everything else is dropped.
         assign pal_we   = iow_fall & tdata_cs & idx_reg[4];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               idx_reg <= 5'd0;
            end else if (iow_fall && status_cs) begin
               idx_reg <= bus_d[4:0];
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < 16; i++) begin
                  palette_reg[i] <= 4'(i);
               end
               pal_out <= 4'd0;
            end else begin
               if (pal_we) begin
                  palette_reg[idx_reg[3:0]] <= bus_d[3:0];
               end
               pal_out <= palette_reg[pal_idx];
            end
         end
      end else begin : g_identity
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               pal_out <= 4'd0;
            end else begin
               pal_out <= pal_idx;
            end
         end
      end
   endgenerate

   // --------------------------------------------------------- read path
   logic [7:0] status_val;

   assign status_val = {4'b1111, vs_sync_reg, 2'b10, ~de_sync_reg};
   assign bus_dir    = (crtc_cs | status_cs) & ~bus_ior_l;

   always_comb begin
      bus_out = 8'h00;
      if (status_cs) begin
         bus_out = status_val;
      end else if (crtc_cs && bus_a[0]) begin
         bus_out = crtc_data;
      end
   end

   // ------------------------------------------------- wait-state machine
   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_A    = 2'd1,
      W_B    = 2'd2,
      W_DONE = 2'd3
   } wait_state_t;

   wait_state_t state_reg;
   wait_state_t state_next;
   logic [7:0]  tmo_reg;
   logic [7:0]  tmo_next;
   logic        memsel;
   logic        tmo_hit;

   assign memsel  = bus_mem_cs & (~strb_sync_reg[1] | ~strb_sync_reg[0]);
   assign tmo_hit = ((tmo_reg + 8'd1) == WAIT_TIMEOUT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= W_IDLE;
         tmo_reg   <= 8'd0;
      end else begin
         state_reg <= state_next;
         tmo_reg   <= tmo_next;
      end
   end

   // Ready is combinational so it drops in the same cycle memsel rises.
   always_comb begin
      state_next = state_reg;
      tmo_next   = tmo_reg;
      bus_rdy    = 1'b1;
      case (state_reg)
         W_IDLE: begin
            tmo_next = 8'd0;
            bus_rdy  = ~memsel;
            if (memsel) state_next = W_A;
         end
         W_A: begin
            bus_rdy  = 1'b0;
            tmo_next = tmo_reg + 8'd1;
            if (!memsel)                       state_next = W_IDLE;
            else if (tmo_hit)                  state_next = W_DONE;
            else if (clk_seq == WAIT_SLOT_A)   state_next = W_B;
         end
         W_B: begin
            bus_rdy  = 1'b0;
            tmo_next = tmo_reg + 8'd1;
            if (!memsel)                       state_next = W_IDLE;
            else if (tmo_hit)                  state_next = W_DONE;
            else if (clk_seq == WAIT_SLOT_B)   state_next = W_DONE;
         end
         default: begin
            tmo_next = 8'd0;
            if (!memsel) state_next = W_IDLE;
         end
      endcase
      if (USE_BUS_WAIT == 0) begin
         state_next = W_IDLE;
         tmo_next   = 8'd0;
         bus_rdy    = 1'b1;
      end
   end

   // ------------------------------------------------------------- blink
   generate
      if (BLINK_FROM_VSYNC != 0) begin : g_blink_frames
         logic       vs_prev_reg;
         logic [4:0] frame_cnt_reg;
         logic       vs_fall;

         assign vs_fall = vs_prev_reg & ~vs_sync_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               vs_prev_reg   <= 1'b1;
               frame_cnt_reg <= 5'd0;
               blink         <= 1'b0;
            end else begin
               vs_prev_reg <= vs_sync_reg;
               if (!splashscreen && vs_fall) begin
                  if ((frame_cnt_reg + 5'd1) == BLINK_FRAMES) begin
                     frame_cnt_reg <= 5'd0;
                     blink         <= ~blink;
                  end else begin
                     frame_cnt_reg <= frame_cnt_reg + 5'd1;
                  end
               end
            end
         end
      end else begin : g_blink_free
         logic [23:0] blink_cnt_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               blink_cnt_reg <= 24'd0;
               blink         <= 1'b0;
            end else if (!splashscreen) begin
               if (blink_cnt_reg == BLINK_MAX) begin
                  blink_cnt_reg <= 24'd0;
                  blink         <= ~blink;
               end else begin
                  blink_cnt_reg <= blink_cnt_reg + 24'd1;
               end
            end
         end
      end
   endgenerate

endmodule
